// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sevenseg_pkg : glyph codes, FSM encoding and result type for 7-seg receive
// Rev 1.0
// ---------------------------------------------------------------------------
package sevenseg_pkg;

  localparam int SEG_W = 7;

  // Active-low {a,b,c,d,e,f,g}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       invalid;
  } glyph_t;

endpackage
`default_nettype wire

// File: rtl/seg_glyph_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_glyph_decode : combinational active-low 7-seg pattern to hex digit
// Rev 1.0
// ---------------------------------------------------------------------------
module seg_glyph_decode
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output glyph_t           o_glyph
);

  always_comb begin
    o_glyph = '{digit: 4'h0, blank: 1'b0, invalid: 1'b0};
    case (i_seg)
      SEG_0:     o_glyph.digit = 4'h0;
      SEG_1:     o_glyph.digit = 4'h1;
      SEG_2:     o_glyph.digit = 4'h2;
      SEG_3:     o_glyph.digit = 4'h3;
      SEG_4:     o_glyph.digit = 4'h4;
      SEG_5:     o_glyph.digit = 4'h5;
      SEG_6:     o_glyph.digit = 4'h6;
      SEG_7:     o_glyph.digit = 4'h7;
      SEG_8:     o_glyph.digit = 4'h8;
      SEG_9:     o_glyph.digit = 4'h9;
      SEG_A:     o_glyph.digit = 4'hA;
      SEG_B:     o_glyph.digit = 4'hB;
      SEG_C:     o_glyph.digit = 4'hC;
      SEG_D:     o_glyph.digit = 4'hD;
      SEG_E:     o_glyph.digit = 4'hE;
      SEG_F:     o_glyph.digit = 4'hF;
      SEG_BLANK: o_glyph.blank = 1'b1;
      default:   o_glyph.invalid = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sevenseg_rx_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sevenseg_rx_decoder : sync + debounce a 7-seg bus, emit each new stable glyph
// Optional invalid-pattern counter with SEVSEG_ERR_CNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module sevenseg_rx_decoder
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       digit,
  output logic             blank,
  output logic             invalid,
  output logic [SEG_W-1:0] seg_raw
`ifdef SEVSEG_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int                c_CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0]   r_sync1, r_sync2, r_prev, r_last;
  logic [c_CNT_W-1:0] r_cnt;
  logic [0:0]         r_state, w_state_nxt;
  logic [3:0]         r_digit;
  logic               r_blank, r_invalid;
  logic               w_stable, w_load;
  glyph_t             w_glyph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= SEG_BLANK;
      r_sync2 <= SEG_BLANK;
    end else begin
      r_sync1 <= seg_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= SEG_BLANK;
      r_cnt  <= '0;
    end else if (r_sync2 != r_prev) begin
      r_prev <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt != c_CNT_MAX) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign w_stable = (r_sync2 == r_prev) && (r_cnt == c_CNT_MAX);
  // r_last doubles as seg_raw: both always hold the most recently loaded pattern
  assign w_load   = w_stable && (r_prev != r_last) &&
                    ((r_state == ST_IDLE) || out_ready);

  seg_glyph_decode u_decode (
    .i_seg   (r_prev),
    .o_glyph (w_glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_load) w_state_nxt = ST_PEND;
      ST_PEND: if (out_ready && !w_load) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == ST_PEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit   <= 4'h0;
      r_blank   <= 1'b0;
      r_invalid <= 1'b0;
      r_last    <= SEG_BLANK;
    end else if (w_load) begin
      r_digit   <= w_glyph.digit;
      r_blank   <= w_glyph.blank;
      r_invalid <= w_glyph.invalid;
      r_last    <= r_prev;
    end
  end

  assign digit   = r_digit;
  assign blank   = r_blank;
  assign invalid = r_invalid;
  assign seg_raw = r_last;

`ifdef SEVSEG_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             r_err_cnt <= 8'h00;
    else if (w_load && w_glyph.invalid && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_rx_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sevenseg_rx_decoder : directed scoreboard bench for sevenseg_rx_decoder
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sevenseg_rx_decoder;

  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       invalid;
    logic [6:0] raw;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] digit;
  logic       blank, invalid;
  logic [6:0] seg_raw;
`ifdef SEVSEG_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat;
  exp_t sb_q[$];
  logic [6:0] glyph_tab [16];

  always #5 clk = ~clk;

  sevenseg_rx_decoder #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digit     (digit),
    .blank     (blank),
    .invalid   (invalid),
    .seg_raw   (seg_raw)
`ifdef SEVSEG_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: table lookup of the hex glyphs
  task automatic push(input logic [6:0] p);
    exp_t e;
    e = '{digit: 4'h0, blank: 1'b0, invalid: 1'b1, raw: p};
    if (p == 7'h7F) begin
      e.blank = 1'b1; e.invalid = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (glyph_tab[i] == p) begin
          e.digit = 4'(i); e.invalid = 1'b0;
        end
    end
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(input string tag, input int budget, output int l);
    exp_t e;
    l = 0;
    while (out_valid !== 1'b1 && l < budget) begin
      @(negedge clk);
      l++;
    end
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check({tag, " scoreboard"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check({tag, " digit"},   32'(digit),   32'(e.digit));
        check({tag, " blank"},   32'(blank),   32'(e.blank));
        check({tag, " invalid"}, 32'(invalid), 32'(e.invalid));
        check({tag, " seg_raw"}, 32'(seg_raw), 32'(e.raw));
      end
    end
  endtask

  task automatic handshake(input logic ready_after);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = ready_after;
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic saw = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw = 1'b1;
    end
    check(tag, 32'(saw), 32'd0);
  endtask

  initial begin
    glyph_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    repeat (3) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst digit",     32'(digit),     32'd0);
    check("rst blank",     32'(blank),     32'd0);
    check("rst invalid",   32'(invalid),   32'd0);
    check("rst seg_raw",   32'(seg_raw),   32'h7F);
`ifdef SEVSEG_ERR_CNT_EN
    check("rst err_cnt",   32'(err_cnt),   32'd0);
`endif

    // Digit 2 with latency and hold under backpressure
    rst = 1'b0;
    seg_in = 7'b0010010;
    push(seg_in);
    wait_valid("d2", 20, lat);
    check("d2 latency", 32'(lat), 32'd7);
    repeat (5) begin
      @(negedge clk);
      check("d2 hold", {27'd0, out_valid, digit}, {27'd0, 1'b1, 4'd2});
    end
    handshake(1'b0);
    check("d2 drop valid", 32'(out_valid), 32'd0);

    // Short glitch must not re-emit or emit the glitch value
    seg_in = 7'b1001111;
    push(seg_in);
    wait_valid("d1", 20, lat);
    handshake(1'b0);
    seg_in = 7'b0000000;
    repeat (2) @(negedge clk);
    seg_in = 7'b1001111;
    expect_quiet("glitch quiet", 20);

    // Streaming with ready held high, including blank
    out_ready = 1'b1;
    foreach (glyph_tab[i]) begin end
    begin
      logic [6:0] seq [3];
      seq = '{7'b0000001, 7'b1111111, 7'b0110000};
      for (int k = 0; k < 3; k++) begin
        seg_in = seq[k];
        push(seg_in);
        wait_valid($sformatf("stream%0d", k), 12, lat);
        handshake(1'b1);
        expect_quiet($sformatf("stream%0d quiet", k), 3);
      end
    end

    // Invalid pattern
    seg_in = 7'b1010101;
    push(seg_in);
    wait_valid("inv", 12, lat);
    handshake(1'b1);
`ifdef SEVSEG_ERR_CNT_EN
    check("err_cnt one", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 300; i++) begin
      seg_in = (i % 2 == 0) ? 7'b0101010 : 7'b1010101;
      repeat (10) @(negedge clk);
    end
    check("err_cnt sat", 32'(err_cnt), 32'd255);
`endif
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure: 5 stabilises then is overtaken by 6 before handshake
    seg_in = 7'b0000110;
    push(seg_in);
    wait_valid("bp3", 12, lat);
    seg_in = 7'b0100100;
    repeat (10) @(negedge clk);
    check("bp hold5", {27'd0, out_valid, digit}, {27'd0, 1'b1, 4'd3});
    seg_in = 7'b0100000;
    push(seg_in);
    repeat (10) @(negedge clk);
    check("bp hold6", {27'd0, out_valid, digit}, {27'd0, 1'b1, 4'd3});
    handshake(1'b0);
    wait_valid("bp6", 1, lat);
    check("bp6 no bubble", 32'(lat), 32'd0);
    handshake(1'b0);
    expect_quiet("bp quiet", 15);

    // Asynchronous reset while pending, then re-emission
    seg_in = 7'b0001000;
    push(seg_in);
    wait_valid("pre-rst", 12, lat);
    rst = 1'b1;
    #1;
    check("async rst valid",   32'(out_valid), 32'd0);
    check("async rst seg_raw", 32'(seg_raw),   32'h7F);
    @(negedge clk);
    rst = 1'b0;
    push(seg_in);
    wait_valid("post-rst", 20, lat);
    check("post-rst latency", 32'(lat), 32'd7);
    handshake(1'b0);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sevenseg_rx_decoder.md
Name: sevenseg_rx_decoder

Overview:
- Reverse direction of the board's 7-segment display drivers: samples an active-low 7-segment pattern bus (a..g, a = bit 6, g = bit 0) from pins or another block.
- Synchronises and debounces the bus, then decodes the pattern back to a 4-bit hex digit.
- Emits each newly stable pattern once over a valid/ready handshake.
- Used for self-checking display paths and for reading 7-segment-coded inputs.

Parameters:
- STABLE_CYCLES, default 4: consecutive identical synchronised samples required before a pattern is accepted. Legal range is 2..255.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: asynchronous, active-high reset.
- seg_in, input, 7: active-low segment bus {a,b,c,d,e,f,g}. Asynchronous to clk.
- out_valid, output, 1: decoded result pending.
- out_ready, input, 1: consumer accepts the result.
- digit, output, 4: decoded hex value. 0 when blank or invalid.
- blank, output, 1: pattern was all-off (7'b1111111).
- invalid, output, 1: pattern is neither a hex glyph nor blank.
- seg_raw, output, 7: the accepted pattern, verbatim.

Behaviour:
- Reset is asynchronous on rst, active-high, with one clock.
- Reset values:
  - out_valid=0, digit=0, blank=0, invalid=0, seg_raw=7'h7F.
  - Synchroniser flops = 7'h7F, prev=7'h7F, stability counter=0, last_emitted=7'h7F, FSM=IDLE.
- Synchroniser: 2-flop synchroniser on seg_in, giving s.
- Stability counter (width $clog2(STABLE_CYCLES)):
  - If s != prev: prev<=s and cnt<=0.
  - Else: cnt increments, saturating at STABLE_CYCLES-1.
  - stable = (s==prev) && (cnt==STABLE_CYCLES-1).
- Glyph table (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - Blank=1111111. Any other code sets invalid=1.
- load = stable && (prev != last_emitted) && (state==IDLE || out_ready).
- FSM has two states:
  - IDLE: out_valid=0. On load: output registers <= decode(prev), last_emitted<=prev, go to PEND.
  - PEND: out_valid=1; outputs held constant while out_ready=0.
    - On out_ready with load true: reload the new result and stay in PEND (back-to-back, no bubble).
    - On out_ready without load: go to IDLE.
- Latency: with seg_in constant from edge 1, out_valid is high after edge STABLE_CYCLES+3 (7 cycles at the default), provided the FSM is IDLE.
- Duplicate suppression: a pattern equal to last_emitted is never re-emitted, even after an intervening glitch shorter than STABLE_CYCLES.
- Power-up blank is not emitted.
- Backpressure: patterns that become stable and then change while in PEND are dropped. Only the pattern stable at handshake time can be emitted next. There is no queue.
- Result bits are mutually exclusive: blank and invalid are never both 1, and digit=0 whenever either is 1.
- rst asserted mid-operation discards any pending result immediately (asynchronous). After release, the pipeline restarts from blank.

Optional Feature:
- Macro: SEVSEG_ERR_CNT_EN.
- When defined:
  - Adds output port err_cnt[7:0], reset to 0.
  - Increments on each load whose decoded pattern is invalid; saturates at 255.
- When undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package sevenseg_pkg holds:
  - SEG_0..SEG_F and SEG_BLANK as 7-bit constants.
  - FSM state encoding (IDLE=1'b0, PEND=1'b1).
  - SEG_W=7.
- Natural sub-module: seg_glyph_decode, purely combinational. Maps seg[6:0] to {digit, blank, invalid}.
- Synchroniser, stability counter and FSM remain in the top module.

Test Plan:
- Reset, then seg_in=7'b0010010 held, out_ready=0 -> out_valid rises after edge 7; digit=2, blank=0, invalid=0; outputs hold until out_ready=1, then out_valid=0.
- seg_in=1001111 held, then a 2-cycle pulse to 0000000, then back to 1001111 -> exactly one result (digit=1); no result for 8.
- out_ready=1 continuously; sequence 0000001 -> 1111111 -> 0110000, each held 10 cycles -> three results: digit=0; blank=1 (digit=0); digit=14.
- seg_in=1010101 held -> invalid=1, digit=0, seg_raw=1010101. With SEVSEG_ERR_CNT_EN defined, err_cnt=1; 300 alternating invalid patterns leave err_cnt=255.
- out_ready=0 during PEND with digit 3; seg_in changes to 5 (stable), then 6 (stable); then out_ready pulses -> next result is 6; 5 is never emitted.
- rst asserted while out_valid=1 -> out_valid=0 in the same cycle; after release with unchanged seg_in, the pattern is re-emitted after 7 cycles.
